// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed common-anode 7-segment scanner with dp, blanking,
// leading-zero suppression, PWM brightness and frame-synchronous update.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS    = 8,
    parameter int SCAN_DIV_LOG2 = 15,
    parameter bit SYNC_UPDATE   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cs,
    input  logic [4*NUM_DIGITS-1:0] i_data,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    input  logic [NUM_DIGITS-1:0]   i_blank,
    input  logic                    i_lzs,
    input  logic [3:0]              i_bright,
    output logic [7:0]              o_seg,
    output logic [NUM_DIGITS-1:0]   o_sel,
    output logic                    o_frame
);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic [SCAN_DIV_LOG2-1:0] pre;
    logic [IW-1:0]            idx, hi;
    logic [4*NUM_DIGITS-1:0]  lat_data, sh_data;
    logic [NUM_DIGITS-1:0]    lat_dp, lat_blank, sh_dp, sh_blank;
    logic [3:0]               nib;
    logic                     tick, wrap, lit;

    // hi = highest nonzero digit (0 when all zero, so digit 0 is never suppressed)
    always_comb begin
        hi = '0;
        for (int k = 0; k < NUM_DIGITS; k++)
            if (sh_data[4*k +: 4] != 4'd0) hi = IW'(k);
        tick = &pre;
        wrap = tick && idx == LAST;
        nib  = sh_data[4*idx +: 4];
        lit  = pre[SCAN_DIV_LOG2-1 -: 4] <= i_bright && !sh_blank[idx] && !(i_lzs && idx > hi);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre       <= '0;
            idx       <= '0;
            lat_data  <= '0;
            lat_dp    <= '0;
            lat_blank <= '0;
            sh_data   <= '0;
            sh_dp     <= '0;
            sh_blank  <= '0;
            o_seg     <= 8'hFF;
            o_sel     <= '1;
            o_frame   <= 1'b0;
        end else begin
            pre <= pre + 1'b1;
            if (tick) idx <= wrap ? '0 : idx + 1'b1;
            if (cs) {lat_data, lat_dp, lat_blank} <= {i_data, i_dp, i_blank};
            if (!SYNC_UPDATE || wrap) {sh_data, sh_dp, sh_blank} <= {lat_data, lat_dp, lat_blank};
            o_frame <= wrap;
            o_sel   <= lit ? ~(NUM_DIGITS'(1) << idx) : '1;
            o_seg   <= lit ? {~sh_dp[idx], HEX[nib]} : 8'hFF;
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: random and directed stimulus against a cycle-count based display model.
module tb_seg7_scan_ctrl;
    localparam int ND = 4;
    localparam int SD = 4;
    localparam int FR = ND << SD;
    localparam logic [7:0] HEXT [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic        clk = 0, reset = 1, cs = 0, i_lzs = 0;
    logic [15:0] i_data = 0;
    logic [3:0]  i_dp = 0, i_blank = 0, i_bright = 4'hF;
    logic [7:0]  s_seg, u_seg;
    logic [3:0]  s_sel, u_sel;
    logic        s_frame, u_frame;

    int n_checks = 0, n_fail = 0;
    int n = 0;
    bit started = 0;
    logic [23:0] m_lat = 0, m_sh = 0, m_u = 0;
    logic [11:0] e_s = 12'hFFF, e_u = 12'hFFF;
    logic        e_frame = 0;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV_LOG2(SD), .SYNC_UPDATE(1)) dut_sync (
        .clk(clk), .reset(reset), .cs(cs), .i_data(i_data), .i_dp(i_dp), .i_blank(i_blank),
        .i_lzs(i_lzs), .i_bright(i_bright), .o_seg(s_seg), .o_sel(s_sel), .o_frame(s_frame));

    seg7_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV_LOG2(SD), .SYNC_UPDATE(0)) dut_unsync (
        .clk(clk), .reset(reset), .cs(cs), .i_data(i_data), .i_dp(i_dp), .i_blank(i_blank),
        .i_lzs(i_lzs), .i_bright(i_bright), .o_seg(u_seg), .o_sel(u_sel), .o_frame(u_frame));

    // What the display must show for shadow state st, digit d, phase ph
    function automatic logic [11:0] model_out(logic [23:0] st, int d, int ph, logic lzs, logic [3:0] br);
        logic [15:0] data = st[23:8];
        logic [3:0]  dp = st[7:4];
        logic [3:0]  bl = st[3:0];
        logic [3:0]  nib;
        int          hi = 0;
        logic        lit;
        for (int k = 0; k < ND; k++)
            if (data[4*k +: 4] != 4'd0) hi = k;
        nib = data[4*d +: 4];
        lit = ph <= int'(br) && !bl[d] && !(lzs && d > hi);
        return lit ? {4'(~(32'd1 << d)), ~dp[d], HEXT[nib][6:0]} : 12'hFFF;
    endfunction

    // n = clocks since reset; digit and phase follow from plain arithmetic on it
    always @(posedge clk) begin
        started <= 1;
        if (reset) begin
            n       <= 0;
            m_lat   <= 0;
            m_sh    <= 0;
            m_u     <= 0;
            e_s     <= 12'hFFF;
            e_u     <= 12'hFFF;
            e_frame <= 0;
        end else begin
            e_s     <= model_out(m_sh, (n >> SD) % ND, (n % (1 << SD)) >> (SD - 4), i_lzs, i_bright);
            e_u     <= model_out(m_u, (n >> SD) % ND, (n % (1 << SD)) >> (SD - 4), i_lzs, i_bright);
            e_frame <= n % FR == FR - 1;
            if (n % FR == FR - 1) m_sh <= m_lat;
            m_u <= m_lat;
            if (cs) m_lat <= {i_data, i_dp, i_blank};
            n <= n + 1;
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at n=%0d", nm, act, exp, n);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("sync_out", {20'd0, s_sel, s_seg}, {20'd0, e_s});
            chk("sync_frame", {31'd0, s_frame}, {31'd0, e_frame});
            chk("unsync_out", {20'd0, u_sel, u_seg}, {20'd0, e_u});
            chk("unsync_frame", {31'd0, u_frame}, {31'd0, e_frame});
        end
    end

    task automatic wait_mod(int m);
        int w = 0;
        while (n % FR != m && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_mod timeout: got n=%0d expected n%%%0d==%0d", n, FR, m);
        end
    endtask

    task automatic pin_at(int m, bit u, string nm, logic [3:0] sel, logic [7:0] seg);
        wait_mod(m);
        chk(nm, {20'd0, u ? {u_sel, u_seg} : {s_sel, s_seg}}, {20'd0, sel, seg});
    endtask

    task automatic next_frame();
        @(negedge clk);
        wait_mod(0);
    endtask

    task automatic write(logic [15:0] d, logic [3:0] dp, logic [3:0] bl);
        i_data  = d;
        i_dp    = dp;
        i_blank = bl;
        cs      = 1;
        @(negedge clk);
        cs = 0;
    endtask

    task automatic count_low(string nm, int exp);
        int lo = 0;
        repeat (1 << SD) begin
            @(negedge clk);
            if (s_sel != 4'hF) lo++;
        end
        chk(nm, lo, exp);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_out", {20'd0, s_sel, s_seg}, 32'hFFF);
        chk("reset_frame", {31'd0, s_frame}, 0);
        reset = 0;
        write(16'h12AF, 0, 0);
        next_frame();
        chk("frame_pulse", {31'd0, s_frame}, 1);
        pin_at(2, 0, "d0_F", 4'hE, 8'h8E);
        chk("frame_low", {31'd0, s_frame}, 0);
        pin_at(18, 0, "d1_A", 4'hD, 8'h88);
        pin_at(34, 0, "d2_2", 4'hB, 8'hA4);
        pin_at(50, 0, "d3_1", 4'h7, 8'hF9);

        i_lzs = 1;
        write(16'h0050, 0, 0);
        next_frame();
        pin_at(2, 0, "lzs_d0", 4'hE, 8'hC0);
        pin_at(18, 0, "lzs_d1", 4'hD, 8'h92);
        pin_at(34, 0, "lzs_d2", 4'hF, 8'hFF);
        pin_at(50, 0, "lzs_d3", 4'hF, 8'hFF);
        write(16'h0000, 0, 0);
        next_frame();
        pin_at(2, 0, "lzs0_d0", 4'hE, 8'hC0);
        pin_at(18, 0, "lzs0_d1", 4'hF, 8'hFF);

        i_lzs = 0;
        write(16'h8888, 4'b0010, 4'b1000);
        next_frame();
        pin_at(2, 0, "dp_d0", 4'hE, 8'h80);
        pin_at(18, 0, "dp_d1", 4'hD, 8'h00);
        pin_at(34, 0, "dp_d2", 4'hB, 8'h80);
        pin_at(50, 0, "blank_d3", 4'hF, 8'hFF);

        i_bright = 3;
        next_frame();
        count_low("bright3_low", 4);
        i_bright = 0;
        next_frame();
        count_low("bright0_low", 1);
        i_bright = 15;

        next_frame();
        wait_mod(10);
        write(16'h12AF, 0, 0);
        pin_at(34, 0, "sync_old", 4'hB, 8'h80);
        next_frame();
        pin_at(34, 0, "sync_new", 4'hB, 8'hA4);
        wait_mod(63);
        write(16'h0003, 0, 0);
        pin_at(2, 0, "wrap_cs_old", 4'hE, 8'h8E);
        next_frame();
        pin_at(2, 0, "wrap_cs_new", 4'hE, 8'hB0);

        next_frame();
        wait_mod(2);
        write(16'h0005, 0, 0);
        pin_at(4, 1, "unsync_old", 4'hE, 8'hB0);
        pin_at(5, 1, "unsync_new", 4'hE, 8'h92);

        wait_mod(40);
        reset = 1;
        @(negedge clk);
        chk("midreset_out", {20'd0, s_sel, s_seg}, 32'hFFF);
        chk("midreset_frame", {31'd0, s_frame}, 0);
        reset = 0;
        pin_at(2, 0, "post_reset_d0", 4'hE, 8'hC0);

        for (int i = 0; i < 3000; i++) begin
            cs      = $urandom % 8 == 0;
            i_data  = 16'($urandom);
            i_dp    = 4'($urandom);
            i_blank = $urandom % 4 == 0 ? 4'($urandom) : 4'd0;
            if ($urandom % 50 == 0) i_lzs = 1'($urandom);
            if ($urandom % 40 == 0) i_bright = 4'($urandom);
            reset   = $urandom % 400 == 0;
            @(negedge clk);
        end
        reset = 0;
        cs    = 0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
